set_assoc_cache: RTL
====================

Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Successor to the direct-mapped cache; same device-side and RAM-side port set, so it drops into the existing cache bench and simulated RAM unchanged.
- Sits between a 32-bit word-addressed requester and a single-word-per-transaction backing RAM.
- Adds associativity, dirty tracking with line write-back, and per-set round-robin replacement.

Parameters:
- ADDRESS_WIDTH, 16, byte address width.
- INDEX_WIDTH, 3, set index bits; 2**INDEX_WIDTH sets.
- WORD_OFFSET_WIDTH, 2, words per line = 2**WORD_OFFSET_WIDTH.
- WAYS, 2, associativity; power of 2, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cache_address  in  ADDRESS_WIDTH  device byte address; bits [1:0] ignored
- cache_rd  in  1  read request, held until cache_ready
- cache_wr  in  1  write request, held until cache_ready; must not be high with cache_rd
- cache_byte_enable  in  4  write byte lanes
- cache_data_wr  in  32  write data
- cache_data_out  out  32  read data, valid while cache_ready=1
- cache_ready  out  1  one-cycle completion pulse
- ram_address  out  ADDRESS_WIDTH  word-aligned RAM byte address
- ram_rd  out  1  RAM read pulse
- ram_wr  out  1  RAM write pulse
- ram_data_wr  out  32  RAM write data
- ram_byte_enable  out  4  always 4'hf
- ram_data_rd  in  32  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM completion, one cycle after the pulse

Behaviour:
- Address split:
  - [1:0] byte offset
  - [WORD_OFFSET_WIDTH+1:2] word offset
  - next INDEX_WIDTH bits: index
  - remaining bits: tag
- Per line: valid, dirty, tag, and 2**WORD_OFFSET_WIDTH data words. Per set: log2(WAYS)-bit round-robin pointer rr.
- Reset: all valid/dirty=0, rr=0, state IDLE. All outputs 0; ram_byte_enable=4'hf.
- Reset mid-operation abandons the transaction. No cache_ready is issued and no further RAM pulses occur.
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - If cache_rd|cache_wr and cache_ready==0, latch address, byte enables and data; go to COMPARE.
  - Requests are ignored in the cycle cache_ready is high.
- COMPARE: check all ways in parallel.
  - Hit: go to RESPOND.
  - Miss, victim selection: lowest-numbered invalid way if any, else way rr.
  - Miss, next state: WRITEBACK if victim valid&dirty, else REFILL.
- WRITEBACK:
  - For each word w=0..N-1: pulse ram_wr for exactly one cycle with ram_address={victim tag,index,w,2'b00} and the word data.
  - Wait for ram_ready before issuing the next word.
  - After the last word, clear dirty and go to REFILL.
- REFILL:
  - For each word w: pulse ram_rd for one cycle at {req tag,index,w,2'b00}; capture ram_data_rd on ram_ready.
  - After the last word: set tag, valid=1, dirty=0; set rr[index]=(victim+1) mod WAYS; go to RESPOND.
- RESPOND:
  - Read: cache_data_out = addressed word.
  - Write: merge cache_data_wr into the word per byte enable; set dirty=1.
  - Assert cache_ready for one cycle, then return to IDLE.
  - cache_data_out is updated only on read completions and holds otherwise.
- ram_rd and ram_wr are never high together and never high for two consecutive cycles.
- Timing: the RAM-side cost is 2 cycles per word.
  - Hit: cache_ready high 3 cycles after the request is sampled.
  - Clean miss: hit latency + 2*2**WORD_OFFSET_WIDTH cycles.
  - Dirty miss: clean miss latency plus the same amount again.
- A hit does not update rr; replacement is FIFO-like round-robin, not LRU.
- WAYS=1 degenerates to a direct-mapped write-back cache; rr is unused.

Test Plan (defaults; RAM word i holds 32'(i); address 60 = index 3, tag 0, word 3):
- Cold read 60 -> ram_rd at 48,52,56,60 one pulse each, no ram_wr; cache_ready with cache_data_out=0x0000000F.
- Then read 56 -> hit, no RAM activity, data 0x0000000E, ready 3 cycles after request.
- Read 60, 188, 316 (all index 3) -> fills way0 then way1. 316 evicts way0 (rr=0) with no write-back since clean. Re-read 188 -> hit; re-read 60 -> miss.
- Write 0xAABBCCDD, be=4'b0011 to 60 after fill -> hit; then read 60 -> 0x0000CCDD.
- Dirty eviction: after the write above, read 188 then 316 -> ram_wr to 48,52,56,60 precedes refill ram_rd. RAM word at 60 becomes 0x0000CCDD; a later read 60 returns 0x0000CCDD.
- Write miss to 8 (index 0) with be=4'hf, data 0x12345678 -> refill 0..12, then read 8 -> 0x12345678. Assert rst mid-refill -> no cache_ready; subsequent read 8 misses and returns 0x00000002.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate cache placed between a
// 32-bit word-addressed requester and a one-word-per-transaction RAM.
// Victims are chosen by a per-set round-robin pointer, and dirty lines are
// written back before the refill.
module set_assoc_cache #(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int INDEX_WIDTH       = 3,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WAYS              = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cache_address,
    input  logic                     cache_rd,
    input  logic                     cache_wr,
    input  logic [3:0]               cache_byte_enable,
    input  logic [31:0]              cache_data_wr,
    output logic [31:0]              cache_data_out,
    output logic                     cache_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [31:0]              ram_data_wr,
    output logic [3:0]               ram_byte_enable,
    input  logic [31:0]              ram_data_rd,
    input  logic                     ram_ready
);

    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << WORD_OFFSET_WIDTH;
    localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state, state_next;

    // Line storage
    logic [SETS-1:0]      valid_q [WAYS];
    logic [SETS-1:0]      dirty_q [WAYS];
    logic [TAG_WIDTH-1:0] tag_q   [WAYS][SETS];
    logic [31:0]          data_q  [WAYS][SETS][WORDS];
    logic [WAY_BITS-1:0]  rr_q    [SETS];

    // Latched request
    logic [TAG_WIDTH-1:0]         req_tag;
    logic [INDEX_WIDTH-1:0]       req_index;
    logic [WORD_OFFSET_WIDTH-1:0] req_word;
    logic                         req_wr;
    logic [3:0]                   req_be;
    logic [31:0]                  req_data;

    // Line transfer bookkeeping
    logic [WAY_BITS-1:0]          way_sel;
    logic [WORD_OFFSET_WIDTH-1:0] word_cnt;
    logic                         pending;
    logic                         last_word;

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic                victim_found;

    // The byte offset is never used: the cache is word-addressed.
    logic unused_byte_offset;
    assign unused_byte_offset = ^cache_address[1:0];

    assign ram_byte_enable = 4'hf;
    assign last_word       = (word_cnt == '1);

    // Parallel tag compare and victim choice for the latched request
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim_found = 1'b0;
        victim       = rr_q[req_index];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!victim_found && !valid_q[w][req_index]) begin
                victim_found = 1'b1;
                victim       = WAY_BITS'(w);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and RAM pulses; a pulse is issued only when no word is outstanding
    always_comb begin
        state_next = state;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        case (state)
            IDLE: begin
                if ((cache_rd || cache_wr) && !cache_ready) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit)
                    state_next = RESPOND;
                else if (valid_q[victim][req_index] && dirty_q[victim][req_index])
                    state_next = WRITEBACK;
                else
                    state_next = REFILL;
            end
            WRITEBACK: begin
                if (!pending)                    ram_wr     = 1'b1;
                else if (ram_ready && last_word) state_next = REFILL;
            end
            REFILL: begin
                if (!pending)                    ram_rd     = 1'b1;
                else if (ram_ready && last_word) state_next = RESPOND;
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM address and write data for the word being transferred
    always_comb begin
        ram_address = '0;
        ram_data_wr = '0;
        if (state == WRITEBACK) begin
            ram_address = {tag_q[way_sel][req_index], req_index, word_cnt, 2'b00};
            ram_data_wr = data_q[way_sel][req_index][word_cnt];
        end else if (state == REFILL) begin
            ram_address = {req_tag, req_index, word_cnt, 2'b00};
        end
    end

    // Control state: request latch, line status bits, replacement pointers, responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag        <= '0;
            req_index      <= '0;
            req_word       <= '0;
            req_wr         <= 1'b0;
            req_be         <= '0;
            req_data       <= '0;
            way_sel        <= '0;
            word_cnt       <= '0;
            pending        <= 1'b0;
            cache_ready    <= 1'b0;
            cache_data_out <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            cache_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if ((cache_rd || cache_wr) && !cache_ready) begin
                        req_tag   <= cache_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                        req_index <= cache_address[WORD_OFFSET_WIDTH+2 +: INDEX_WIDTH];
                        req_word  <= cache_address[2 +: WORD_OFFSET_WIDTH];
                        req_wr    <= cache_wr;
                        req_be    <= cache_byte_enable;
                        req_data  <= cache_data_wr;
                    end
                end
                COMPARE: begin
                    way_sel  <= hit ? hit_way : victim;
                    word_cnt <= '0;
                    pending  <= 1'b0;
                end
                WRITEBACK, REFILL: begin
                    if (!pending) begin
                        pending <= 1'b1;
                    end else if (ram_ready) begin
                        pending  <= 1'b0;
                        word_cnt <= word_cnt + WORD_OFFSET_WIDTH'(1);
                        if (last_word) begin
                            dirty_q[way_sel][req_index] <= 1'b0;
                            if (state == REFILL) begin
                                valid_q[way_sel][req_index] <= 1'b1;
                                if (WAYS > 1) rr_q[req_index] <= way_sel + WAY_BITS'(1);
                            end
                        end
                    end
                end
                RESPOND: begin
                    cache_ready <= 1'b1;
                    if (req_wr) dirty_q[way_sel][req_index] <= 1'b1;
                    else        cache_data_out <= data_q[way_sel][req_index][req_word];
                end
                default: ;
            endcase
        end
    end

    // Line data and tags: refill capture and byte-lane write merge
    always_ff @(posedge clk) begin
        if (state == REFILL && pending && ram_ready) begin
            data_q[way_sel][req_index][word_cnt] <= ram_data_rd;
            if (last_word) tag_q[way_sel][req_index] <= req_tag;
        end
        if (state == RESPOND && req_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (req_be[b]) data_q[way_sel][req_index][req_word][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
    end

endmodule
